// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one in-order memory port between fetch and LSU; optional MEM_ARB_STARVE_GUARD_EN bounds fetch starvation
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUT_WIDTH = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_addr_valid,
  output logic inst_addr_ready,
  input  logic [31:0] inst_addr,
  output logic inst_line_valid,
  input  logic inst_line_ready,
  output logic [31:0] inst_line,
  input  logic data_req_valid,
  output logic data_req_ready,
  input  logic [31:0] data_req_addr,
  input  logic data_req_wr,
  input  logic [31:0] data_req_wdata,
  input  logic [3:0] data_req_wstrb,
  output logic data_resp_valid,
  input  logic data_resp_ready,
  output logic [31:0] data_resp_rdata,
  output logic mem_req_valid,
  input  logic mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic mem_req_wr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0] mem_req_wstrb,
  input  logic mem_resp_valid,
  output logic mem_resp_ready,
  input  logic [31:0] mem_resp_data,
  output logic [OUT_WIDTH-1:0] outstanding
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  if (MAX_OUTSTANDING < 1 || 2 ** OUT_WIDTH <= MAX_OUTSTANDING || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;
  state_t state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OUT_WIDTH-1:0] cnt_q, cnt_d;
  logic can_issue, active, sel_d, push, pop, empty, head, force_i;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  assign force_i = inst_addr_valid && starve_q == SW'(STARVE_LIMIT);
  // count cycles fetch loses an unlocked grant to data; cleared by any fetch issue
  always_comb begin
    starve_d = starve_q;
    if (push && !sel_d) starve_d = '0;
    else if (state_q == IDLE && mem_req_valid && sel_d && inst_addr_valid) starve_d = starve_q + 1'b1;
  end
  // starvation counter register
  always_ff @(posedge clk) starve_q <= rst ? '0 : starve_d;
`else
  assign force_i = 1'b0;
`endif
  // grant selection, payload mux, ready paths and response routing
  always_comb begin
    can_issue = cnt_q < OUT_WIDTH'(MAX_OUTSTANDING);
    sel_d = state_q == LOCK_D || (state_q == IDLE && data_req_valid && !force_i);
    active = !rst && (state_q != IDLE || can_issue);
    mem_req_valid = active && (sel_d ? data_req_valid : inst_addr_valid);
    data_req_ready = active && sel_d && mem_req_ready;
    inst_addr_ready = active && !sel_d && mem_req_ready;
    mem_req_addr = sel_d ? data_req_addr : inst_addr;
    mem_req_wr = sel_d && data_req_wr;
    mem_req_wdata = sel_d ? data_req_wdata : '0;
    mem_req_wstrb = sel_d ? data_req_wstrb : '0;
    empty = cnt_q == '0;
    head = tag_q[rd_q];
    inst_line_valid = !rst && !empty && !head && mem_resp_valid;
    data_resp_valid = !rst && !empty && head && mem_resp_valid;
    mem_resp_ready = !rst && !empty && (head ? data_resp_ready : inst_line_ready);
    inst_line = mem_resp_data;
    data_resp_rdata = mem_resp_data;
    outstanding = cnt_q;
    push = mem_req_valid && mem_req_ready;
    pop = mem_resp_valid && mem_resp_ready;
  end
  // lock FSM and order-queue next state
  always_comb begin
    state_d = state_q == IDLE ? (mem_req_valid && !mem_req_ready ? (sel_d ? LOCK_D : LOCK_I) : IDLE)
                              : (push ? IDLE : state_q);
    tag_d = tag_q;
    if (push) tag_d[wr_q] = sel_d;
    wr_d = push ? nxt(wr_q) : wr_q;
    rd_d = pop ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q + OUT_WIDTH'(push) - OUT_WIDTH'(pop);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic inst_addr_valid = 0, inst_addr_ready, inst_line_valid, inst_line_ready = 0;
  logic [31:0] inst_addr = 0, inst_line;
  logic data_req_valid = 0, data_req_ready, data_req_wr = 0, data_resp_valid, data_resp_ready = 0;
  logic [31:0] data_req_addr = 0, data_req_wdata = 0, data_resp_rdata;
  logic [3:0] data_req_wstrb = 0;
  logic mem_req_valid, mem_req_ready = 0, mem_req_wr, mem_resp_valid = 0, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data = 0;
  logic [3:0] mem_req_wstrb;
  logic [2:0] outstanding;
  int n_cmp = 0, n_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_addr_valid(inst_addr_valid), .inst_addr_ready(inst_addr_ready), .inst_addr(inst_addr),
    .inst_line_valid(inst_line_valid), .inst_line_ready(inst_line_ready), .inst_line(inst_line),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_req_addr(data_req_addr),
    .data_req_wr(data_req_wr), .data_req_wdata(data_req_wdata), .data_req_wstrb(data_req_wstrb),
    .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready), .data_resp_rdata(data_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wr(mem_req_wr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_addr_valid = 0; data_req_valid = 0; data_req_wr = 0; data_req_wstrb = 0; data_req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; inst_line_ready = 0; data_resp_ready = 0;
  endtask

  task automatic drain(input int n);
    idle();
    mem_resp_valid = 1; inst_line_ready = 1; data_resp_ready = 1;
    for (int i = 0; i < n; i++) step();
    idle();
  endtask

  task automatic test_reset();
    rst = 1; inst_addr_valid = 1; mem_req_ready = 1; mem_resp_valid = 1; inst_line_ready = 1;
    step();
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid got %b exp 0", mem_req_valid); end
    n_cmp++; if (inst_addr_ready !== 1'b0) begin n_err++; $display("FAIL reset_inst_ready got %b exp 0", inst_addr_ready); end
    n_cmp++; if (mem_resp_ready !== 1'b0) begin n_err++; $display("FAIL reset_mem_resp_ready got %b exp 0", mem_resp_ready); end
    idle(); rst = 0; step();
  endtask

  task automatic test_priority();
    inst_addr_valid = 1; inst_addr = 32'h1FC00000;
    data_req_valid = 1; data_req_addr = 32'h80001000; mem_req_ready = 1;
    #1;
    n_cmp++; if (mem_req_addr !== 32'h80001000) begin n_err++; $display("FAIL prio_first_addr got %h exp 80001000", mem_req_addr); end
    n_cmp++; if ({data_req_ready, inst_addr_ready} !== 2'b10) begin n_err++; $display("FAIL prio_first_ready got %b exp 10", {data_req_ready, inst_addr_ready}); end
    step(); data_req_valid = 0; #1;
    n_cmp++; if (mem_req_addr !== 32'h1FC00000) begin n_err++; $display("FAIL prio_second_addr got %h exp 1fc00000", mem_req_addr); end
    n_cmp++; if ({inst_addr_ready, mem_req_wr, mem_req_wstrb} !== 6'b100000) begin n_err++; $display("FAIL prio_fetch_payload got %b exp 100000", {inst_addr_ready, mem_req_wr, mem_req_wstrb}); end
    step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL prio_outstanding got %0d exp 2", outstanding); end
    mem_resp_valid = 1; mem_resp_data = 32'h11; inst_line_ready = 1; data_resp_ready = 1; #1;
    n_cmp++; if ({data_resp_valid, inst_line_valid, data_resp_rdata} !== {2'b10, 32'h11}) begin n_err++; $display("FAIL prio_resp_data got %b/%b/%h exp 1/0/11", data_resp_valid, inst_line_valid, data_resp_rdata); end
    step(); mem_resp_data = 32'h22; #1;
    n_cmp++; if ({inst_line_valid, data_resp_valid, inst_line} !== {2'b10, 32'h22}) begin n_err++; $display("FAIL prio_resp_inst got %b/%b/%h exp 1/0/22", inst_line_valid, data_resp_valid, inst_line); end
    step();
    n_cmp++; if ({mem_resp_ready, inst_line_valid, data_resp_valid} !== 3'b000) begin n_err++; $display("FAIL empty_resp_reject got %b exp 000", {mem_resp_ready, inst_line_valid, data_resp_valid}); end
    idle(); step();
  endtask

  task automatic test_store();
    data_req_valid = 1; data_req_addr = 32'h80002000; data_req_wr = 1;
    data_req_wdata = 32'hDEADBEEF; data_req_wstrb = 4'b0101; mem_req_ready = 1; #1;
    n_cmp++; if ({mem_req_wr, mem_req_wdata, mem_req_wstrb} !== {1'b1, 32'hDEADBEEF, 4'b0101}) begin n_err++; $display("FAIL store_payload got %b/%h/%b exp 1/deadbeef/0101", mem_req_wr, mem_req_wdata, mem_req_wstrb); end
    step();
    drain(1);
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL store_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_lock();
    inst_addr_valid = 1; inst_addr = 32'h100; mem_req_ready = 0; #1;
    n_cmp++; if ({mem_req_valid, mem_req_addr, inst_addr_ready} !== {1'b1, 32'h100, 1'b0}) begin n_err++; $display("FAIL lock_c1 got %b/%h/%b exp 1/100/0", mem_req_valid, mem_req_addr, inst_addr_ready); end
    step(); data_req_valid = 1; data_req_addr = 32'h200; #1;
    n_cmp++; if ({mem_req_addr, data_req_ready} !== {32'h100, 1'b0}) begin n_err++; $display("FAIL lock_c2 got %h/%b exp 100/0", mem_req_addr, data_req_ready); end
    step();
    n_cmp++; if (mem_req_addr !== 32'h100) begin n_err++; $display("FAIL lock_c3 got %h exp 100", mem_req_addr); end
    mem_req_ready = 1; #1;
    n_cmp++; if ({inst_addr_ready, data_req_ready, mem_req_addr} !== {2'b10, 32'h100}) begin n_err++; $display("FAIL lock_release got %b/%b/%h exp 1/0/100", inst_addr_ready, data_req_ready, mem_req_addr); end
    step(); inst_addr_valid = 0; #1;
    n_cmp++; if ({data_req_ready, mem_req_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL lock_next_data got %b/%h exp 1/200", data_req_ready, mem_req_addr); end
    step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL lock_outstanding got %0d exp 2", outstanding); end
    drain(2);
  endtask

  task automatic test_in_order();
    mem_req_ready = 1;
    inst_addr_valid = 1; inst_addr = 32'h10; step();
    inst_addr_valid = 0; data_req_valid = 1; data_req_addr = 32'h20; step();
    data_req_valid = 0; inst_addr_valid = 1; inst_addr = 32'h30; step();
    idle(); #1;
    n_cmp++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL order_outstanding got %0d exp 3", outstanding); end
    mem_resp_valid = 1; mem_resp_data = 32'hA; data_resp_ready = 1; inst_line_ready = 0; #1;
    n_cmp++; if ({inst_line_valid, data_resp_valid, mem_resp_ready} !== 3'b100) begin n_err++; $display("FAIL order_backpressure got %b exp 100", {inst_line_valid, data_resp_valid, mem_resp_ready}); end
    step();
    n_cmp++; if ({outstanding, mem_resp_ready} !== {3'd3, 1'b0}) begin n_err++; $display("FAIL order_hold got %0d/%b exp 3/0", outstanding, mem_resp_ready); end
    inst_line_ready = 1; #1;
    n_cmp++; if ({mem_resp_ready, inst_line} !== {1'b1, 32'hA}) begin n_err++; $display("FAIL order_resp0 got %b/%h exp 1/a", mem_resp_ready, inst_line); end
    step(); mem_resp_data = 32'hB; #1;
    n_cmp++; if ({data_resp_valid, inst_line_valid, data_resp_rdata} !== {2'b10, 32'hB}) begin n_err++; $display("FAIL order_resp1 got %b/%b/%h exp 1/0/b", data_resp_valid, inst_line_valid, data_resp_rdata); end
    step(); mem_resp_data = 32'hC; #1;
    n_cmp++; if ({inst_line_valid, data_resp_valid, inst_line} !== {2'b10, 32'hC}) begin n_err++; $display("FAIL order_resp2 got %b/%b/%h exp 1/0/c", inst_line_valid, data_resp_valid, inst_line); end
    step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL order_drained got %0d exp 0", outstanding); end
  endtask

  task automatic test_full();
    mem_req_ready = 1; inst_addr_valid = 1; inst_addr = 32'h40;
    for (int i = 0; i < 4; i++) step();
    data_req_valid = 1; data_req_addr = 32'h300; #1;
    n_cmp++; if ({outstanding, inst_addr_ready, data_req_ready, mem_req_valid} !== {3'd4, 3'b000}) begin n_err++; $display("FAIL full_block got %0d/%b/%b/%b exp 4/0/0/0", outstanding, inst_addr_ready, data_req_ready, mem_req_valid); end
    mem_resp_valid = 1; inst_line_ready = 1; #1;
    n_cmp++; if ({mem_resp_ready, data_req_ready} !== 2'b10) begin n_err++; $display("FAIL full_pop_no_push got %b/%b exp 1/0", mem_resp_ready, data_req_ready); end
    step(); mem_resp_valid = 0; #1;
    n_cmp++; if ({outstanding, data_req_ready, mem_req_addr} !== {3'd3, 1'b1, 32'h300}) begin n_err++; $display("FAIL full_refill got %0d/%b/%h exp 3/1/300", outstanding, data_req_ready, mem_req_addr); end
    step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_back_to_4 got %0d exp 4", outstanding); end
    mem_resp_valid = 1; inst_line_ready = 1; data_resp_ready = 1;
    for (int i = 0; i < 3; i++) step();
    #1;
    n_cmp++; if ({data_resp_valid, inst_line_valid} !== 2'b10) begin n_err++; $display("FAIL full_wrap_head got %b exp 10", {data_resp_valid, inst_line_valid}); end
    step(); idle();
  endtask

  task automatic test_reset_mid();
    mem_req_ready = 1; inst_addr_valid = 1; inst_addr = 32'h50;
    for (int i = 0; i < 3; i++) step();
    mem_req_ready = 0; step();
    n_cmp++; if ({outstanding, mem_req_valid} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL mid_pre got %0d/%b exp 3/1", outstanding, mem_req_valid); end
    rst = 1; mem_req_ready = 1; mem_resp_valid = 1; inst_line_ready = 1; step();
    n_cmp++; if ({outstanding, mem_req_valid, inst_addr_ready, mem_resp_ready, inst_line_valid} !== {3'd0, 4'b0000}) begin n_err++; $display("FAIL mid_reset got %0d/%b/%b/%b/%b exp 0/0/0/0/0", outstanding, mem_req_valid, inst_addr_ready, mem_resp_ready, inst_line_valid); end
    rst = 0; mem_resp_valid = 0; mem_req_ready = 0; data_req_valid = 1; data_req_addr = 32'h400; #1;
    n_cmp++; if ({mem_req_addr, outstanding} !== {32'h400, 3'd0}) begin n_err++; $display("FAIL mid_idle_after got %h/%0d exp 400/0", mem_req_addr, outstanding); end
    idle(); step();
  endtask

`ifdef MEM_ARB_STARVE_GUARD_EN
  task automatic test_starve();
    inst_addr_valid = 1; inst_addr = 32'h60; data_req_valid = 1; data_req_addr = 32'h500; mem_req_ready = 1;
    mem_resp_valid = 1; inst_line_ready = 1; data_resp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (data_req_ready !== 1'b1) begin n_err++; $display("FAIL starve_data_%0d got %b exp 1", i, data_req_ready); end
      step();
    end
    n_cmp++; if ({inst_addr_ready, data_req_ready, mem_req_addr} !== {2'b10, 32'h60}) begin n_err++; $display("FAIL starve_force got %b/%b/%h exp 1/0/60", inst_addr_ready, data_req_ready, mem_req_addr); end
    step();
    n_cmp++; if (data_req_ready !== 1'b1) begin n_err++; $display("FAIL starve_cleared got %b exp 1", data_req_ready); end
    drain(1);
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_priority();
    test_store();
    test_lock();
    test_in_order();
    test_full();
    test_reset_mid();
`ifdef MEM_ARB_STARVE_GUARD_EN
    test_starve();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one in-order memory request/response port between the instruction-fetch address/line channels and the LSU data channel.
- Sits between the fetch stage's inst_addr/inst_line handshake pair, the data-access request/response pair, and the single cache/bus port.
- Records the source of every issued request in an order queue, so each in-order response returns to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 4, maximum requests issued but not yet answered (order-queue depth, ≥1)
- OUT_WIDTH, 3, width of the outstanding counter; must satisfy 2**OUT_WIDTH > MAX_OUTSTANDING
- STARVE_LIMIT, 8, consecutive lost-arbitration cycles before fetch is force-granted (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_addr_valid  in  1  fetch request valid
- inst_addr_ready  out  1  fetch request accepted
- inst_addr  in  32  fetch address
- inst_line_valid  out  1  fetch response valid
- inst_line_ready  in  1  fetch response accepted
- inst_line  out  32  fetch response data
- data_req_valid  in  1  data request valid
- data_req_ready  out  1  data request accepted
- data_req_addr  in  32  data address
- data_req_wr  in  1  1 = store, 0 = load
- data_req_wdata  in  32  store data
- data_req_wstrb  in  4  byte strobes
- data_resp_valid  out  1  data response valid (load data or store ack)
- data_resp_ready  in  1  data response accepted
- data_resp_rdata  out  32  load data; don't-care for store acks
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accepted
- mem_req_addr  out  32  memory address
- mem_req_wr  out  1  store flag
- mem_req_wdata  out  32  store data
- mem_req_wstrb  out  4  strobes; 4'b0000 for fetch requests
- mem_resp_valid  in  1  memory response valid
- mem_resp_ready  out  1  memory response accepted
- mem_resp_data  in  32  memory response data
- outstanding  out  OUT_WIDTH  number of issued, unanswered requests

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: lock clear, order queue empty, outstanding = 0, starve counter = 0. While rst is high, every valid and ready output is forced to 0.
- Handshake: a transfer occurs when valid & ready in the same cycle. Requesters hold valid and payload stable until accepted. The memory holds response valid and data until accepted.
- Issue gate: can_issue = (outstanding < MAX_OUTSTANDING). Push and pop in the same cycle are legal. A pop does not free a slot for a push in the same cycle.
- Arbitration when unlocked and can_issue:
  - Data has fixed priority: grant data if data_req_valid, else grant inst if inst_addr_valid.
- Payload muxing:
  - mem_req_valid = granted source valid. Address, wr, wdata and wstrb come from the granted source.
  - For a fetch grant: wr = 0, wdata = 0, wstrb = 0.
- Ready paths: a requester's ready = mem_req_ready & granted-to-it. Ready is combinational from mem_req_ready; no extra latency.
- Lock FSM:
  - States: IDLE, LOCK_I, LOCK_D.
  - IDLE → LOCK_x when mem_req_valid & ~mem_req_ready. The grant stays frozen on source x regardless of new arrivals.
  - LOCK_x → IDLE on the mem_req handshake.
  - No other transitions.
- Order queue: a 1-bit source tag FIFO (0 = inst, 1 = data).
  - Push on mem_req handshake; pop on mem_resp handshake.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - outstanding += push − pop (net 0 on a simultaneous push and pop).
- Response routing (head = oldest tag):
  - Head = inst: inst_line_valid = mem_resp_valid, inst_line = mem_resp_data, mem_resp_ready = inst_line_ready.
  - Head = data: the same mapping onto data_resp_*.
  - The non-head response valid is 0.
  - Queue empty: mem_resp_ready = 0 and both response valids = 0. A response with no matching request is never accepted.
- Latency: zero added cycles on both request and response paths (combinational pass-through).
- Mid-operation reset: state clears in one cycle. The memory port is reset by the same rst, so no stale responses arrive afterwards.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- When defined:
  - A counter increments each cycle in which inst_addr_valid = 1, the arbiter is unlocked, and data wins the grant.
  - The counter clears on any inst handshake.
  - When the counter equals STARVE_LIMIT, the next unlocked grant goes to inst even if data_req_valid = 1. The counter clears when that grant's handshake completes.
- When undefined: strict data priority, and no counter logic is present.

Test Plan:
- Simultaneous request: inst_addr_valid = 1 (0x1FC00000) and data_req_valid = 1 (0x80001000, load) with mem_req_ready = 1 → data issued first; inst issued next cycle; outstanding = 2.
- Lock hold: inst granted with mem_req_ready = 0 for 3 cycles, data_req_valid rises in cycle 2 → mem_req_addr stays the inst address until the handshake; data issues the cycle after.
- In-order routing: issue inst, data, inst, then return responses 0xA, 0xB, 0xC → inst_line = 0xA, data_resp_rdata = 0xB, inst_line = 0xC. Hold inst_line_ready = 0 during the first response → mem_resp_ready = 0 until it rises.
- Full: 4 issued and none answered → both requester readys = 0. Respond once with a new request pending → the new request issues the cycle after the pop; outstanding returns to 4.
- Reset: assert rst with 3 outstanding and a locked request pending → next cycle outstanding = 0, all valids and readys = 0, FSM = IDLE.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_LIMIT = 8: data_req_valid held continuously with inst_addr_valid = 1 → inst is granted after 8 data grants.
